// File: rtl/dvp_pkg.sv
// Shared types and constants for the synthetic DVP camera source.
package dvp_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VS     = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_BYTE  = 2'd0,
    PAT_LINE  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_ALT   = 2'd3
  } pattern_e;

endpackage

// File: rtl/dvp_pclk_gen.sv
// Pixel clock generator: pclk runs at clk/2. The fall tick marks the clk
// cycle whose closing edge drives pclk low, so logic updated on that edge
// changes together with the pclk falling edge.
module dvp_pclk_gen (
  input  logic clk,
  input  logic rst_n,
  output logic pclk,
  output logic fall_tick
);

  // Toggle register producing a 50% duty pixel clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk <= 1'b0;
    end else begin
      pclk <= ~pclk;
    end
  end

  assign fall_tick = pclk;

endmodule

// File: rtl/dvp_pattern_tx.sv
// Synthetic DVP sensor: produces pclk, vsync, href and data bytes with the
// timing of a parallel camera so the capture path can run without a sensor.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int               DATA_W    = 8,
  parameter int               H_BYTES   = 1280,
  parameter int               H_BLANK   = 144,
  parameter int               V_LINES   = 480,
  parameter int               VS_LEN    = 64,
  parameter int               V_BACK    = 32,
  parameter int               V_FRONT   = 32,
  parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        pattern,
  output logic              pclk,
  output logic              vsync,
  output logic              href,
  output logic [DATA_W-1:0] d,
  output logic              frame_done,
  output logic              busy
);

  // Terminal counts; counters reload to zero instead of relying on overflow
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_LEN - 1);
  localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BACK - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BYTES - 1);
  localparam logic [CNT_W-1:0] HBL_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VL_LAST  = CNT_W'(V_LINES - 1);
  localparam logic [CNT_W-1:0] VF_LAST  = CNT_W'(V_FRONT - 1);

  logic             fall_tick;
  state_e           state;
  pattern_e         pat_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] line_cnt;

  dvp_pclk_gen u_pclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .pclk      (pclk),
    .fall_tick (fall_tick)
  );

  function automatic logic [DATA_W-1:0] pixel_value(
    input pattern_e         pat,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] l
  );
    logic [DATA_W-1:0] v;
    case (pat)
      PAT_BYTE:  v = DATA_W'(b);
      PAT_LINE:  v = DATA_W'(l);
      PAT_CONST: v = CONST_VAL;
      default:   v = b[0] ? '1 : '0;
    endcase
    return v;
  endfunction

  // Frame sequencer; all DVP outputs are registered and move only on fall ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pat_q      <= PAT_BYTE;
      cnt        <= '0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fall_tick) begin
        case (state)
          IDLE: begin
            if (enable) begin
              pat_q <= pattern_e'(pattern);
              vsync <= 1'b1;
              busy  <= 1'b1;
              cnt   <= '0;
              state <= VS;
            end
          end
          VS: begin
            if (cnt == VS_LAST) begin
              vsync <= 1'b0;
              cnt   <= '0;
              state <= VBACK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          VBACK: begin
            if (cnt == VB_LAST) begin
              href     <= 1'b1;
              byte_cnt <= '0;
              line_cnt <= '0;
              d        <= pixel_value(pat_q, '0, '0);
              cnt      <= '0;
              state    <= ACTIVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACTIVE: begin
            if (byte_cnt == HB_LAST) begin
              href  <= 1'b0;
              d     <= '0;
              cnt   <= '0;
              state <= (line_cnt == VL_LAST) ? VFRONT : HBLANK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              d        <= pixel_value(pat_q, byte_cnt + 1'b1, line_cnt);
            end
          end
          HBLANK: begin
            if (cnt == HBL_LAST) begin
              line_cnt <= line_cnt + 1'b1;
              byte_cnt <= '0;
              href     <= 1'b1;
              d        <= pixel_value(pat_q, '0, line_cnt + 1'b1);
              cnt      <= '0;
              state    <= ACTIVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          VFRONT: begin
            if (cnt == VF_LAST) begin
              frame_done <= 1'b1;
              cnt        <= '0;
              if (enable) begin
                pat_q <= pattern_e'(pattern);
                vsync <= 1'b1;
                busy  <= 1'b1;
                state <= VS;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx with a byte scoreboard: expected pixel
// bytes are queued when a frame is requested and popped as href bytes appear.
module tb_dvp_pattern_tx;
  import dvp_pkg::*;

  localparam int DATA_W  = 8;
  localparam int H_BYTES = 4;
  localparam int H_BLANK = 2;
  localparam int V_LINES = 3;
  localparam int VS_LEN  = 2;
  localparam int V_BACK  = 1;
  localparam int V_FRONT = 2;
  localparam int FRAME_CLK = 2 * (VS_LEN + V_BACK + V_LINES * H_BYTES +
                                  (V_LINES - 1) * H_BLANK + V_FRONT);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [1:0]        pattern;
  logic              pclk;
  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] d;
  logic              frame_done;
  logic              busy;

  int         evals = 0;
  int         fails = 0;
  int         cyc = 0;
  int         vs_rise_cyc = 0;
  logic       prev_vs = 1'b0;
  logic [7:0] exp_q[$];

  dvp_pattern_tx #(
    .DATA_W  (DATA_W),
    .H_BYTES (H_BYTES),
    .H_BLANK (H_BLANK),
    .V_LINES (V_LINES),
    .VS_LEN  (VS_LEN),
    .V_BACK  (V_BACK),
    .V_FRONT (V_FRONT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pattern    (pattern),
    .pclk       (pclk),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] expByte(input logic [1:0] pat, input int b, input int l);
    case (pat)
      2'd0:    return 8'(b);
      2'd1:    return 8'(l);
      2'd2:    return 8'hA5;
      default: return (b % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    evals++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(negedge clk);
    cyc++;
    if (vsync && !prev_vs) vs_rise_cyc = cyc;
    prev_vs = vsync;
  endtask

  task automatic pushFrame(input logic [1:0] pat);
    for (int l = 0; l < V_LINES; l++)
      for (int b = 0; b < H_BYTES; b++)
        exp_q.push_back(expByte(pat, b, l));
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] pat);
    int drive_cyc;
    int budget;
    pattern   = pat;
    enable    = en;
    drive_cyc = cyc;
    if (en) begin
      pushFrame(pat);
      budget = 0;
      while (!vsync && budget < 8) begin
        stepClk();
        budget++;
      end
      checkOutput("start_latency", 32'(vsync && (cyc - drive_cyc) >= 1 && (cyc - drive_cyc) <= 2), 32'd1);
    end
  endtask

  task automatic idleCheck(input string tag, input int n);
    logic any;
    any = 1'b0;
    repeat (n) begin
      stepClk();
      if (vsync || href || busy || frame_done || d != '0) any = 1'b1;
    end
    checkOutput(tag, 32'(any), 32'd0);
  endtask

  // Runs one frame that has just started (vsync already high), changes the
  // pattern mid-frame, and either queues the next frame or drops enable on line 1
  task automatic runFrame(input logic [1:0] next_pat, input logic keep);
    int         fstart;
    int         vs_periods;
    int         bursts;
    int         budget;
    int         idx;
    logic       prev_href;
    logic       bad_low;
    logic       overlap;
    logic       done;
    logic [7:0] e;
    fstart     = vs_rise_cyc;
    vs_periods = 0;
    bursts     = 0;
    budget     = 0;
    idx        = 0;
    prev_href  = 1'b0;
    bad_low    = 1'b0;
    overlap    = 1'b0;
    done       = 1'b0;
    checkOutput("frame_started", 32'(vsync), 32'd1);
    pattern = next_pat;
    if (keep) pushFrame(next_pat);
    while (!done && budget < 4 * FRAME_CLK) begin
      stepClk();
      budget++;
      if (pclk) begin
        if (vsync) vs_periods++;
        if (vsync && href) overlap = 1'b1;
        if (href) begin
          if (!prev_href) begin
            bursts++;
            if (!keep && bursts == 2) enable = 1'b0;
          end
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("pixel_%0d", idx), 32'(d), 32'(e));
          end
          idx++;
        end else if (d != '0) begin
          bad_low = 1'b1;
        end
        prev_href = href;
      end
      if (frame_done) done = 1'b1;
    end
    checkOutput("frame_done_seen", 32'(done), 32'd1);
    checkOutput("frame_length_clk", 32'(cyc - fstart), 32'(FRAME_CLK));
    checkOutput("vsync_periods", 32'(vs_periods), 32'(VS_LEN));
    checkOutput("href_bursts", 32'(bursts), 32'(V_LINES));
    checkOutput("d_zero_outside_href", 32'(bad_low), 32'd0);
    checkOutput("vsync_href_overlap", 32'(overlap), 32'd0);
    checkOutput("bytes_left", 32'(exp_q.size()), keep ? 32'(V_LINES * H_BYTES) : 32'd0);
    checkOutput("vsync_at_done", 32'(vsync), 32'(keep));
    checkOutput("busy_at_done", 32'(busy), 32'(keep));
  endtask

  // Linear directed sequence
  initial begin
    int         toggles;
    int         n;
    int         budget;
    logic       prev_p;
    logic       any;
    logic       seen_done;
    logic [7:0] e;

    rst_n   = 1'b0;
    enable  = 1'b0;
    pattern = 2'd0;
    repeat (3) stepClk();
    checkOutput("reset_pclk", 32'(pclk), 32'd0);
    checkOutput("reset_vsync", 32'(vsync), 32'd0);
    checkOutput("reset_href", 32'(href), 32'd0);
    checkOutput("reset_d", 32'(d), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    rst_n   = 1'b1;
    toggles = 0;
    prev_p  = pclk;
    any     = 1'b0;
    repeat (20) begin
      stepClk();
      if (pclk != prev_p) toggles++;
      prev_p = pclk;
      if (vsync || href || busy || frame_done || d != '0) any = 1'b1;
    end
    checkOutput("idle_pclk_toggles", 32'(toggles), 32'd20);
    checkOutput("idle_outputs_quiet", 32'(any), 32'd0);

    applyStimulus(1'b1, PAT_BYTE);
    runFrame(PAT_LINE, 1'b1);
    runFrame(PAT_CONST, 1'b1);
    runFrame(PAT_ALT, 1'b1);
    runFrame(PAT_BYTE, 1'b0);
    idleCheck("idle_after_stop", 12);

    applyStimulus(1'b1, PAT_BYTE);
    n      = 0;
    budget = 0;
    while (n < 2 && budget < 100) begin
      stepClk();
      budget++;
      if (pclk && href) begin
        e = exp_q.pop_front();
        checkOutput("pre_reset_pixel", 32'(d), 32'(e));
        n++;
      end
    end
    checkOutput("reached_active", 32'(n), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", 32'({pclk, vsync, href, busy, frame_done, d}), 32'd0);
    seen_done = 1'b0;
    any       = 1'b0;
    repeat (6) begin
      stepClk();
      if (frame_done) seen_done = 1'b1;
      if (vsync || href || busy || d != '0) any = 1'b1;
    end
    checkOutput("no_frame_done_on_reset", 32'(seen_done), 32'd0);
    checkOutput("outputs_held_in_reset", 32'(any), 32'd0);
    exp_q.delete();

    rst_n = 1'b1;
    applyStimulus(1'b1, PAT_BYTE);
    runFrame(PAT_LINE, 1'b0);
    idleCheck("idle_after_restart", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule

// File: doc/dvp_pattern_tx.md
# dvp_pattern_tx

Synthetic DVP camera source. Generates pixel clock, VSYNC, HREF and byte data exactly as a parallel-DVP sensor would, so the DVP capture path and the UDP packetiser downstream of it can be exercised on hardware and in simulation without a camera attached. It sits at the sensor end of the DVP interface and drives the same pins the capture logic samples.

## Interface

Parameters:
- DATA_W, 8, DVP data bus width
- H_BYTES, 1280, active bytes per line (HREF high length, in pclk periods)
- H_BLANK, 144, HREF-low pclk periods between consecutive lines
- V_LINES, 480, active lines per frame
- VS_LEN, 64, VSYNC-high length in pclk periods
- V_BACK, 32, pclk periods from VSYNC fall to first HREF rise
- V_FRONT, 32, pclk periods from last HREF fall to frame end
- CONST_VAL, 8'hA5, data byte for pattern 2

Ports:
- clk  in  1  system clock; pclk = clk/2
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- enable  in  1  level; request continuous frame generation
- pattern  in  2  pattern select, sampled at frame start
- pclk  out  1  DVP pixel clock, 50% duty, clk/2
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- d  out  DATA_W  pixel byte; 0 whenever href low
- frame_done  out  1  one-clk pulse at end of each frame
- busy  out  1  high from frame start to frame_done

## Operation

- pclk: toggle register, reset 0. "fall tick" = clk cycle in which pclk is 1 (next edge drives it to 0). All DVP outputs update only on fall ticks, so they change on pclk falling edges and are stable at pclk rising edges.
- States: IDLE, VS, VBACK, ACTIVE, HBLANK, VFRONT. One pclk-period counter (16 b), one byte counter (16 b), one line counter (16 b).
- IDLE: all outputs 0. On fall tick with enable=1: latch pattern, vsync<=1, busy<=1, -> VS.
- VS: VS_LEN periods vsync high; then vsync<=0 -> VBACK.
- VBACK: V_BACK periods; then href<=1, byte=0 -> ACTIVE.
- ACTIVE: H_BYTES periods href high, byte counter increments per period. After last byte: if line = V_LINES-1 -> VFRONT, else -> HBLANK. href<=0, d<=0.
- HBLANK: H_BLANK periods, then line+1, href<=1 -> ACTIVE.
- VFRONT: V_FRONT periods, then frame_done pulses 1 clk, busy<=0. If enable=1 -> directly VS (next frame starts same fall tick, pattern re-latched); else -> IDLE.
- Data (byte index b, line index l, low DATA_W bits): pattern 0: b; pattern 1: l; pattern 2: CONST_VAL; pattern 3: 0x00 on even b, all-ones on odd b.
- enable deassertion mid-frame: frame completes; no truncation. pattern change mid-frame: ignored until next frame start.
- Reset mid-frame: all outputs and state to 0/IDLE immediately; no frame_done.

## Timing

- Reset values: pclk 0, vsync 0, href 0, d 0, frame_done 0, busy 0.
- Start latency: enable high -> vsync rises at first fall tick (<=2 clk).
- Frame length in pclk periods: VS_LEN + V_BACK + V_LINES*H_BYTES + (V_LINES-1)*H_BLANK + V_FRONT; clk cycles = 2x.
- Back-to-back frames: zero gap between frame_done and next vsync rise.
- Parameters all >=1; counters compared against PARAM-1 (wrap handled by reload, not overflow).

## Structure

- Package dvp_pkg: state enum, pattern codes (PAT_BYTE=0, PAT_LINE=1, PAT_CONST=2, PAT_ALT=3), counter width constant CNT_W=16.
- Sub-module dvp_pclk_gen: pclk toggle plus fall-tick strobe; rest is one FSM in dvp_pattern_tx.

## Test plan

Bench params H_BYTES=4, H_BLANK=2, V_LINES=3, VS_LEN=2, V_BACK=1, V_FRONT=2 (21 pclk = 42 clk per frame).
- Reset, enable=0 for 20 clk -> pclk toggles, vsync/href/d/busy stay 0.
- enable=1, pattern=0 for one frame -> vsync high 2 pclk, 3 href bursts of 4, d=00,01,02,03 each line, frame_done 42 clk after vsync rise.
- pattern=1 -> lines carry d=00, 01, 02; pattern=2 -> all active bytes A5; pattern=3 -> 00,FF,00,FF.
- enable held high -> second vsync rise on same fall tick as frame_done; change pattern mid-frame -> takes effect only next frame.
- enable dropped during line 1 -> frame finishes, frame_done, then IDLE with outputs 0.
- rst_n asserted during ACTIVE -> href/d/vsync 0 asynchronously, no frame_done; after release restarts cleanly from VS.
